fwd_stall_ctrl: RTL and testbench
=================================

# fwd_stall_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS datapath. It owns all data forwarding into the EX stage and generates every pipeline-register enable and flush. It covers an NSRC-operand forwarding network with register-0 suppression, a counted multi-bubble load-use interlock, dcache-wait freezing, icache-miss bubbling, taken-branch squashing, and a saturating stall-cycle counter. It sits beside the pipeline registers and replaces ad-hoc stall logic in the datapath top.

## Interface
Parameters:
- DATA_W, 32, data word width
- REG_AW, 5, register-select width
- NSRC, 2, source operands per instruction
- LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..7)
- STALL_CNT_W, 16, stall counter width

Ports. One clock; reset is asynchronous and active-low (CLK, nRST).
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ex_src_sel  in  NSRC*REG_AW  EX-stage source register numbers, operand i at [i*REG_AW +: REG_AW]
- ex_src_rdat  in  NSRC*DATA_W  EX-stage register-file read values
- ex_src_fwd  out  NSRC*DATA_W  forwarded operand values
- id_src_sel  in  NSRC*REG_AW  ID-stage source register numbers
- id_src_used  in  NSRC  per-operand "actually read" flags
- ex_wen, ex_memread  in  1 each  EX instruction writes a register / is a load
- ex_wsel  in  REG_AW  EX destination
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_wen, mem_memread, mem_memreq  in  1 each  MEM instruction writes / is a load / accesses dcache
- mem_wsel  in  REG_AW;  mem_result  in  DATA_W  ALU result in EX/MEM
- wb_wen  in  1;  wb_wsel  in  REG_AW;  wb_wdat  in  DATA_W  final write-back value
- ihit, dhit  in  1 each  cache ready
- stall_clr  in  1  synchronous clear of stall_count
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush  out  1 each  load NOP on the next enabled edge
- stall_count  out  STALL_CNT_W  saturating count of cycles with pc_en=0

## Operation
- Forwarding, per operand i, combinational and in priority order:
  - MEM: mem_wen && !mem_memread && mem_wsel==sel && sel!=0 gives mem_result.
  - WB: wb_wen && wb_wsel==sel && sel!=0 gives wb_wdat.
  - Otherwise ex_src_rdat.
  - Register 0 is never forwarded.
- Load-use detect (lu_det): ex_memread && ex_wen && ex_wsel!=0 && any i with id_src_used[i] && id_src_sel[i]==ex_wsel.
- FSM states: RUN and LU_STALL, plus a 3-bit bubble counter bcnt.
- Per-cycle control, highest priority first:
  1. dwait = mem_memreq && !dhit
     - All enables 0, flushes 0.
     - State and bcnt hold.
  2. ex_branch_taken
     - All enables 1; ifid_flush=1, idex_flush=1.
     - Next state RUN, bcnt=0. Any pending load-use is squashed.
  3. lu = (RUN && lu_det) || LU_STALL
     - pc_en=0, ifid_en=0, idex_en=1, idex_flush=1; exmem_en and memwb_en = 1.
     - From RUN: if LU_BUBBLES>1, go to LU_STALL with bcnt=LU_BUBBLES-1.
     - In LU_STALL: bcnt decrements; when bcnt==1, return to RUN with bcnt=0.
  4. !ihit
     - pc_en=0, ifid_en=1, ifid_flush=1; idex_en, exmem_en and memwb_en = 1.
  5. Otherwise all enables 1, flushes 0.
- stall_count behaviour:
  - Increments when pc_en==0; holds at all-ones.
  - stall_clr wins over increment.

## Timing
- Forwarding and all enable/flush outputs are combinational (Mealy) in the same cycle as their inputs.
- State, bcnt and stall_count update on the CLK rising edge.
- Load-use penalty is exactly LU_BUBBLES cycles absent dwait/branch. Cycles spent in dwait do not decrement bcnt.
- Reset (nRST low, any time, including mid-LU_STALL):
  - state=RUN, bcnt=0, stall_count=0 immediately.
  - While low: all enables 0, flushes 0, ex_src_fwd=ex_src_rdat.
  - First cycle after release behaves as RUN.
- Simultaneous lu_det and !ihit: load-use case wins; the fetch retries during the stall.
- Simultaneous MEM and WB match on the same register: MEM wins.

## Test plan
- Forward priority, NSRC=2:
  - Setup: ex_src_sel={5,5}, mem_wen=1 mem_wsel=5 mem_result=0xAAAA0000, wb_wen=1 wb_wsel=5 wb_wdat=0x1234.
  - Expect both operands = 0xAAAA0000.
  - Drop mem_wen; expect 0x1234.
  - Set sel=0; expect ex_src_rdat.
- Load-use, LU_BUBBLES=1:
  - Setup: ex_memread=1 ex_wen=1 ex_wsel=8, id_src_sel[1]=8 used.
  - Expect exactly 1 cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal flow; stall_count=1.
- Load-use, LU_BUBBLES=3, with a 2-cycle dwait injected in the second bubble:
  - Expect pc_en=0 for 5 cycles and state back to RUN after them.
- Branch during LU_STALL:
  - ex_branch_taken=1 in bubble 2.
  - Expect ifid_flush=idex_flush=1, all enables 1, next state RUN.
- Icache miss: ihit=0 for 4 cycles.
  - Expect pc_en=0, ifid_flush=1 each cycle, downstream enables 1, stall_count +4.
- Reset and saturation:
  - Assert nRST mid-LU_STALL; expect state RUN and stall_count=0.
  - With STALL_CNT_W=4, 20 stall cycles leave stall_count=15.

Source files
------------

// File: rtl/fwd_stall_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX-stage operand forwarding,
// load-use interlock, cache-wait freezing, branch squash and a stall-cycle counter.
module fwd_stall_ctrl #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int NSRC        = 2,
  parameter int LU_BUBBLES  = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NSRC*REG_AW-1:0]   ex_src_sel,
  input  logic [NSRC*DATA_W-1:0]   ex_src_rdat,
  output logic [NSRC*DATA_W-1:0]   ex_src_fwd,
  input  logic [NSRC*REG_AW-1:0]   id_src_sel,
  input  logic [NSRC-1:0]          id_src_used,
  input  logic                     ex_wen,
  input  logic                     ex_memread,
  input  logic [REG_AW-1:0]        ex_wsel,
  input  logic                     ex_branch_taken,
  input  logic                     mem_wen,
  input  logic                     mem_memread,
  input  logic                     mem_memreq,
  input  logic [REG_AW-1:0]        mem_wsel,
  input  logic [DATA_W-1:0]        mem_result,
  input  logic                     wb_wen,
  input  logic [REG_AW-1:0]        wb_wsel,
  input  logic [DATA_W-1:0]        wb_wdat,
  input  logic                     ihit,
  input  logic                     dhit,
  input  logic                     stall_clr,
  output logic                     pc_en,
  output logic                     ifid_en,
  output logic                     idex_en,
  output logic                     exmem_en,
  output logic                     memwb_en,
  output logic                     ifid_flush,
  output logic                     idex_flush,
  output logic [STALL_CNT_W-1:0]   stall_count
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] LU_STALL = 1'b1;

  localparam logic [2:0]             LU_INIT = 3'(LU_BUBBLES - 1);
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

  logic [0:0]      state, state_nxt;
  logic [2:0]      bcnt, bcnt_nxt;
  logic [NSRC-1:0] id_hit;
  logic            lu_det;
  logic            dwait;

  // A load in MEM has no result yet, so it is skipped and WB (or the file) supplies the operand.
  for (genvar g = 0; g < NSRC; g++) begin : g_fwd
    logic [REG_AW-1:0] sel;
    logic              mem_hit;
    logic              wb_hit;

    assign sel     = ex_src_sel[g*REG_AW +: REG_AW];
    assign mem_hit = nRST && mem_wen && !mem_memread && (mem_wsel == sel) && (sel != '0);
    assign wb_hit  = nRST && wb_wen && (wb_wsel == sel) && (sel != '0);

    assign ex_src_fwd[g*DATA_W +: DATA_W] = mem_hit ? mem_result :
                                            wb_hit  ? wb_wdat    :
                                                      ex_src_rdat[g*DATA_W +: DATA_W];

    assign id_hit[g] = id_src_used[g] && (id_src_sel[g*REG_AW +: REG_AW] == ex_wsel);
  end

  assign lu_det = ex_memread && ex_wen && (ex_wsel != '0) && (|id_hit);
  assign dwait  = mem_memreq && !dhit;

  always_comb begin
    // NOTE: every output gets a default up front so no path through the priority chain infers a latch.
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    state_nxt  = state;
    bcnt_nxt   = bcnt;

    if (!nRST) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (dwait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_nxt  = RUN;
      bcnt_nxt   = '0;
    end else if ((state == RUN && lu_det) || state == LU_STALL) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      if (state == RUN) begin
        if (LU_BUBBLES > 1) begin
          state_nxt = LU_STALL;
          bcnt_nxt  = LU_INIT;
        end
      end else if (bcnt == 3'd1) begin
        state_nxt = RUN;
        bcnt_nxt  = '0;
      end else begin
        bcnt_nxt = bcnt - 3'd1;
      end
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset, so reset acts mid-stall without a clock.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      bcnt        <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      if (stall_clr) begin
        stall_count <= '0;
      end else if (!pc_en && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Scoreboard bench for fwd_stall_ctrl: dut_a (LU_BUBBLES=1, 4-bit counter) and
// dut_b (LU_BUBBLES=3, 16-bit counter) share stimulus except the EX load flag.
module tb_fwd_stall_ctrl;

  localparam logic [6:0] C_NORM = 7'b1111100;
  localparam logic [6:0] C_DW   = 7'b0000000;
  localparam logic [6:0] C_BR   = 7'b1111111;
  localparam logic [6:0] C_LU   = 7'b0011101;
  localparam logic [6:0] C_IM   = 7'b0111110;
  localparam logic [6:0] C_RST  = 7'b0000000;
  localparam logic [31:0] R0 = 32'h1111_1111;
  localparam logic [31:0] R1 = 32'h2222_2222;

  typedef struct {
    string       name;
    bit          dut;
    logic [6:0]  ctrl;
    bit          cf;
    logic [31:0] f0;
    logic [31:0] f1;
    bit          cs;
    logic [15:0] sc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  ex_src_sel;
  logic [63:0] ex_src_rdat;
  logic [63:0] fwd_a, fwd_b;
  logic [9:0]  id_src_sel;
  logic [1:0]  id_src_used;
  logic        ex_wen, ex_memread_a, ex_memread_b;
  logic [4:0]  ex_wsel;
  logic        ex_branch_taken;
  logic        mem_wen, mem_memread, mem_memreq;
  logic [4:0]  mem_wsel;
  logic [31:0] mem_result;
  logic        wb_wen;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_wdat;
  logic        ihit, dhit, stall_clr;
  logic [6:0]  ctrl_a, ctrl_b;
  logic [3:0]  sc_a;
  logic [15:0] sc_b;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fwd_stall_ctrl #(.LU_BUBBLES(1), .STALL_CNT_W(4)) dut_a (
    .CLK(clk), .nRST(rst_n),
    .ex_src_sel(ex_src_sel), .ex_src_rdat(ex_src_rdat), .ex_src_fwd(fwd_a),
    .id_src_sel(id_src_sel), .id_src_used(id_src_used),
    .ex_wen(ex_wen), .ex_memread(ex_memread_a), .ex_wsel(ex_wsel),
    .ex_branch_taken(ex_branch_taken),
    .mem_wen(mem_wen), .mem_memread(mem_memread), .mem_memreq(mem_memreq),
    .mem_wsel(mem_wsel), .mem_result(mem_result),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .ihit(ihit), .dhit(dhit), .stall_clr(stall_clr),
    .pc_en(ctrl_a[6]), .ifid_en(ctrl_a[5]), .idex_en(ctrl_a[4]),
    .exmem_en(ctrl_a[3]), .memwb_en(ctrl_a[2]),
    .ifid_flush(ctrl_a[1]), .idex_flush(ctrl_a[0]),
    .stall_count(sc_a)
  );

  fwd_stall_ctrl #(.LU_BUBBLES(3), .STALL_CNT_W(16)) dut_b (
    .CLK(clk), .nRST(rst_n),
    .ex_src_sel(ex_src_sel), .ex_src_rdat(ex_src_rdat), .ex_src_fwd(fwd_b),
    .id_src_sel(id_src_sel), .id_src_used(id_src_used),
    .ex_wen(ex_wen), .ex_memread(ex_memread_b), .ex_wsel(ex_wsel),
    .ex_branch_taken(ex_branch_taken),
    .mem_wen(mem_wen), .mem_memread(mem_memread), .mem_memreq(mem_memreq),
    .mem_wsel(mem_wsel), .mem_result(mem_result),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .ihit(ihit), .dhit(dhit), .stall_clr(stall_clr),
    .pc_en(ctrl_b[6]), .ifid_en(ctrl_b[5]), .idex_en(ctrl_b[4]),
    .exmem_en(ctrl_b[3]), .memwb_en(ctrl_b[2]),
    .ifid_flush(ctrl_b[1]), .idex_flush(ctrl_b[0]),
    .stall_count(sc_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every expectation queued for this cycle is compared at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      check({e.name, ".ctrl"}, 64'(e.dut ? ctrl_b : ctrl_a), 64'(e.ctrl));
      if (e.cf) check({e.name, ".fwd"}, e.dut ? fwd_b : fwd_a, {e.f1, e.f0});
      if (e.cs) check({e.name, ".stall_count"}, 64'(e.dut ? sc_b : {12'b0, sc_a}), 64'(e.sc));
    end
  end

  task automatic push(input string name, input bit dut, input logic [6:0] ctrl,
                      input bit cf, input logic [31:0] f0, input logic [31:0] f1,
                      input bit cs, input logic [15:0] sc);
    exp_t x;
    x.name = name; x.dut = dut; x.ctrl = ctrl;
    x.cf = cf; x.f0 = f0; x.f1 = f1; x.cs = cs; x.sc = sc;
    q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_src_sel = '0;  ex_src_rdat = {R1, R0};
    id_src_sel = '0;  id_src_used = '0;
    ex_wen = 1'b0;    ex_memread_a = 1'b0; ex_memread_b = 1'b0; ex_wsel = '0;
    ex_branch_taken = 1'b0;
    mem_wen = 1'b0;   mem_memread = 1'b0;  mem_memreq = 1'b0;
    mem_wsel = '0;    mem_result = 32'hDEAD_0000;
    wb_wen = 1'b0;    wb_wsel = '0;        wb_wdat = 32'hBEEF_0000;
    ihit = 1'b1;      dhit = 1'b1;         stall_clr = 1'b0;
  endtask

  // EX holds a load to r8 while the ID instruction reads r8 on operand 1.
  task automatic set_load(input bit for_b);
    ex_wen = 1'b1; ex_wsel = 5'd8;
    id_src_sel = {5'd8, 5'd3}; id_src_used = 2'b10;
    if (for_b) ex_memread_b = 1'b1;
    else       ex_memread_a = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    ex_src_sel = {5'd5, 5'd5}; mem_wen = 1'b1; mem_wsel = 5'd5; mem_result = 32'hAAAA_0000;
    tick();
    push("rst_a", 0, C_RST, 1, R0, R1, 1, 16'd0);
    push("rst_b", 1, C_RST, 1, R0, R1, 1, 16'd0);
    tick();
    rst_n = 1'b1;
    idle();

    // Forwarding priority and register-0 suppression
    ex_src_sel = {5'd5, 5'd5};
    mem_wen = 1'b1; mem_wsel = 5'd5; mem_result = 32'hAAAA_0000;
    wb_wen = 1'b1;  wb_wsel = 5'd5;  wb_wdat = 32'h0000_1234;
    push("fwd_mem", 0, C_NORM, 1, 32'hAAAA_0000, 32'hAAAA_0000, 1, 16'd0); tick();
    mem_wen = 1'b0;
    push("fwd_wb", 0, C_NORM, 1, 32'h0000_1234, 32'h0000_1234, 1, 16'd0); tick();
    mem_wen = 1'b1; ex_src_sel = '0;
    push("fwd_r0", 0, C_NORM, 1, R0, R1, 1, 16'd0); tick();
    ex_src_sel = {5'd7, 5'd5}; mem_memread = 1'b1;
    push("fwd_mem_load", 0, C_NORM, 1, 32'h0000_1234, R1, 0, '0); tick();
    idle();

    // Load-use detect boundaries, then LU_BUBBLES=1 interlock on dut_a
    ex_memread_a = 1'b1; ex_wen = 1'b1; ex_wsel = '0; id_src_used = 2'b11;
    push("lu_r0", 0, C_NORM, 0, '0, '0, 1, 16'd0); tick();
    ex_wsel = 5'd8; id_src_sel = {5'd8, 5'd3}; id_src_used = 2'b01;
    push("lu_unused", 0, C_NORM, 0, '0, '0, 0, '0); tick();
    ex_wen = 1'b0; id_src_used = 2'b10;
    push("lu_nowen", 0, C_NORM, 0, '0, '0, 0, '0); tick();
    idle(); set_load(0);
    push("lu1_a", 0, C_LU, 0, '0, '0, 1, 16'd0);
    push("lu1_b_noload", 1, C_NORM, 0, '0, '0, 1, 16'd0); tick();
    idle();
    push("lu1_done", 0, C_NORM, 0, '0, '0, 1, 16'd1); tick();

    // LU_BUBBLES=3 on dut_b with a 2-cycle dcache wait in the second bubble
    set_load(1);
    push("lu3_b1", 1, C_LU, 0, '0, '0, 1, 16'd0); tick();
    idle(); mem_memreq = 1'b1; dhit = 1'b0;
    push("lu3_dw1", 1, C_DW, 0, '0, '0, 1, 16'd1); tick();
    push("lu3_dw2", 1, C_DW, 0, '0, '0, 1, 16'd2); tick();
    mem_memreq = 1'b0; dhit = 1'b1;
    push("lu3_b2", 1, C_LU, 0, '0, '0, 1, 16'd3); tick();
    push("lu3_b3", 1, C_LU, 0, '0, '0, 1, 16'd4); tick();
    push("lu3_run", 1, C_NORM, 0, '0, '0, 1, 16'd5); tick();

    // Branch during LU_STALL; dcache wait still outranks the branch
    set_load(1);
    push("br_lu", 1, C_LU, 0, '0, '0, 1, 16'd5); tick();
    idle(); mem_memreq = 1'b1; dhit = 1'b0; ex_branch_taken = 1'b1;
    push("br_dwait", 1, C_DW, 0, '0, '0, 1, 16'd6); tick();
    mem_memreq = 1'b0; dhit = 1'b1;
    push("br_squash", 1, C_BR, 0, '0, '0, 1, 16'd7); tick();
    ex_branch_taken = 1'b0;
    push("br_run", 1, C_NORM, 0, '0, '0, 1, 16'd7); tick();

    // Icache miss for 4 cycles on dut_a after clearing its counter
    stall_clr = 1'b1;
    push("clr", 0, C_NORM, 0, '0, '0, 0, '0); tick();
    stall_clr = 1'b0; ihit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push("imiss", 0, C_IM, 0, '0, '0, 1, 16'(k)); tick();
    end
    ihit = 1'b1;
    push("imiss_done", 0, C_NORM, 0, '0, '0, 1, 16'd4); tick();

    // Load-use beats icache miss; fetch retries afterwards; clear beats increment
    set_load(0); ihit = 1'b0;
    push("lu_vs_imiss", 0, C_LU, 0, '0, '0, 1, 16'd4); tick();
    ex_memread_a = 1'b0; ex_wen = 1'b0;
    push("imiss_retry", 0, C_IM, 0, '0, '0, 1, 16'd5); tick();
    stall_clr = 1'b1;
    push("clr_wins", 0, C_IM, 0, '0, '0, 1, 16'd6); tick();
    idle();
    push("clr_done", 0, C_NORM, 0, '0, '0, 1, 16'd0); tick();

    // Reset asserted mid-LU_STALL on dut_b
    set_load(1);
    push("rs_lu", 1, C_LU, 0, '0, '0, 0, '0); tick();
    idle();
    ex_src_sel = {5'd5, 5'd5}; mem_wen = 1'b1; mem_wsel = 5'd5; mem_result = 32'hAAAA_0000;
    rst_n = 1'b0;
    push("rs_b", 1, C_RST, 1, R0, R1, 1, 16'd0);
    push("rs_a", 0, C_RST, 1, R0, R1, 1, 16'd0); tick();
    rst_n = 1'b1; idle();
    push("rs_run_b", 1, C_NORM, 0, '0, '0, 1, 16'd0); tick();

    // Saturation of the 4-bit counter over 20 stall cycles
    ihit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      push("sat", 0, C_IM, 0, '0, '0, 1, (k > 15) ? 16'd15 : 16'(k)); tick();
    end
    ihit = 1'b1;
    push("sat_hold", 0, C_NORM, 0, '0, '0, 1, 16'd15);
    push("sat_b_wide", 1, C_NORM, 0, '0, '0, 1, 16'd20); tick();

    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
